// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Single outstanding word fetch over a valid/ready request channel; a response may be parked while decode stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] hold_ir;
    logic            kill;

    logic            handshake_c;
    logic            load_c;
    logic [XLEN-1:0] load_ir_c;

    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc & ALIGN_MASK;
    assign handshake_c    = imem_req_valid && imem_req_ready;

    // IF/ID load source: a live response straight through, or the parked word once stall drops
    always_comb begin
        load_c    = 1'b0;
        load_ir_c = hold_ir;
        case (state)
            S_WAIT: begin
                if (imem_rsp_valid && !kill && !stall) begin
                    load_c    = 1'b1;
                    load_ir_c = imem_rsp_data;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    load_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_REQ;
            pc             <= RESET_PC & ALIGN_MASK;
            req_pc         <= '0;
            hold_ir        <= '0;
            kill           <= 1'b0;
            if_id_valid    <= 1'b0;
            if_id_ir       <= NOP_INSTR;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            // Redirect beats stall and any response; an in-flight fetch is marked for discard
            pc          <= redirect_pc & ALIGN_MASK;
            if_id_valid <= 1'b0;
            if_id_ir    <= NOP_INSTR;
            hold_ir     <= '0;
            case (state)
                S_REQ: begin
                    if (handshake_c) begin
                        req_pc <= pc;
                        kill   <= 1'b1;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        kill  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        kill <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            if (load_c) begin
                if_id_valid    <= 1'b1;
                if_id_ir       <= load_ir_c;
                if_id_pc       <= req_pc;
                if_id_pc_plus4 <= req_pc + XLEN'(4);
                pc             <= req_pc + XLEN'(4);
                state          <= S_REQ;
            end else if (!stall) begin
                if_id_valid <= 1'b0;
                if_id_ir    <= NOP_INSTR;
            end
            case (state)
                S_REQ: begin
                    if (handshake_c) begin
                        req_pc <= pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (stall) begin
                            hold_ir <= imem_rsp_data;
                            state   <= S_HOLD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory model feeds a scoreboard of expected IF/ID entries,
// hand sequences cover stall/redirect corners, and a vector table exercises redirect targets.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    typedef struct packed {
        logic [31:0] rpc;
        logic [31:0] addr;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] acc_q[$];
    vec_t        vecs[5];
    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    int          cnt = 0;
    bit          pend = 1'b0;
    bit          killed = 1'b0;
    logic [31:0] p_addr = 32'h0;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_ir       (if_id_ir),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_8113;
            32'h0000_0008: return 32'hDEAD_BEEF;
            32'hFFFF_FFFC: return 32'h0000_0013;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Memory model: sees the handshake that the next edge will complete, answers lat cycles later.
    // A response overlapped by a redirect is dropped from the scoreboard.
    always begin
        @(posedge clk);
        #2;
        imem_rsp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (redirect_valid) killed = 1'b1;
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = data_of(p_addr);
                    pend           = 1'b0;
                    if (!killed) exp_q.push_back('{pc: p_addr, ir: data_of(p_addr)});
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend   = 1'b1;
                cnt    = lat;
                p_addr = imem_req_addr;
                killed = redirect_valid;
                acc_q.push_back(imem_req_addr);
            end
        end
    end

    // Decode consumes IF/ID whenever it is valid and not stalled
    exp_t e;
    always @(negedge clk) begin
        if (!rst && if_id_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: got pc %h ir %h expected no instruction", if_id_pc, if_id_ir);
            end else begin
                e = exp_q.pop_front();
                check("id_ir", if_id_ir, e.ir);
                check("id_pc", if_id_pc, e.pc);
                check("id_pc_plus4", if_id_pc_plus4, e.pc + 32'd4);
            end
        end
    end

    task automatic wait_req(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge clk);
            if (imem_req_valid === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_req: got timeout expected imem_req_valid");
        end
    endtask

    task automatic wait_pend(input logic [31:0] a, input bit any_addr);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (pend && (any_addr || p_addr == a)) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_pend: got timeout expected request %h", a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rpc: 32'h0000_0103, addr: 32'h0000_0100};
        vecs[1] = '{rpc: 32'hFFFF_FFFF, addr: 32'hFFFF_FFFC};
        vecs[2] = '{rpc: 32'h0000_0002, addr: 32'h0000_0000};
        vecs[3] = '{rpc: 32'h1234_5678, addr: 32'h1234_5678};
        vecs[4] = '{rpc: 32'h8000_0006, addr: 32'h8000_0004};

        // Reset with memory ready
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_id_valid", 32'(if_id_valid), 32'd0);
            check("rst_id_ir", if_id_ir, NOP);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);

        // Sequential fetch; scoreboard checks IF/ID for 0x0 and 0x4
        wait_pend(32'h8, 1'b0);
        for (int i = 0; i < 3; i++)
            check("seq_req_addr", (acc_q.size() > i) ? acc_q[i] : 32'hxxxx_xxxx, 32'(4 * i));

        // Stall while the response for 0x8 arrives
        @(posedge clk); #1;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_req_valid", 32'(imem_req_valid), 32'd0);
            check("stall_id_valid", 32'(if_id_valid), 32'd0);
            check("stall_id_ir", if_id_ir, NOP);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        lat   = 3;
        @(negedge clk);
        check("release_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        check("release_id_valid", 32'(if_id_valid), 32'd1);
        check("release_id_ir", if_id_ir, 32'hDEAD_BEEF);
        check("release_req_valid2", 32'(imem_req_valid), 32'd1);
        check("release_req_addr", imem_req_addr, 32'h0000_000C);

        // Redirect while waiting on a slow response
        wait_pend(32'h0, 1'b1);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        lat            = 1;
        @(negedge clk);
        check("wait_redir_id_valid", 32'(if_id_valid), 32'd0);
        check("wait_redir_id_ir", if_id_ir, NOP);
        check("wait_redir_req_valid", 32'(imem_req_valid), 32'd0);
        wait_req(20);
        check("wait_redir_addr", imem_req_addr, 32'h0000_0100);

        // Redirect while a stalled response is parked
        wait_pend(32'h0, 1'b1);
        @(posedge clk); #1;
        stall = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        check("hold_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        @(negedge clk);
        check("hold_redir_id_valid", 32'(if_id_valid), 32'd0);
        check("hold_redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("hold_redir_addr", imem_req_addr, 32'h0000_0200);

        // Redirect table applied while a request sits unaccepted
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            imem_req_ready = 1'b0;
            wait_req(20);
            @(posedge clk); #1;
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].rpc;
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            acc_q.delete();
            imem_req_ready = 1'b1;
            @(negedge clk);
            check("tbl_req_valid", 32'(imem_req_valid), 32'd1);
            check("tbl_req_addr", imem_req_addr, vecs[v].addr);
            check("tbl_id_valid", 32'(if_id_valid), 32'd0);
            check("tbl_id_ir", if_id_ir, NOP);
            for (int i = 0; i < 20 && acc_q.size() < 2; i++) @(negedge clk);
            check("tbl_acc0", (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx, vecs[v].addr);
            check("tbl_acc1", (acc_q.size() > 1) ? acc_q[1] : 32'hxxxx_xxxx, vecs[v].addr + 32'd4);
        end

        // Drain and confirm every expected instruction reached decode
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("leftover", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
